// File: rtl/multicycle_control.sv
// Main control FSM for the 16-bit multicycle processor: sequences fetch/decode/
// execute/memory/writeback, drives datapath controls and counts retired instructions.
module multicycle_control (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal_op,
    output logic [15:0] instr_count
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12
    } state_e;

    state_e      state_r;
    state_e      next_state_s;
    state_e      exit_state_s;
    logic [15:0] count_r;

    // Where an instruction goes once it retires or is rejected: run is only looked at here and in IDLE
    assign exit_state_s = run ? S_FETCH : S_IDLE;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= 16'h0000;
        end else if (instr_done) begin
            count_r <= count_r + 16'd1;
        end
    end

    // Next-state and state-decoded datapath controls
    always_comb begin
        next_state_s  = state_r;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR load and PC+1 commit only in the cycle memory delivers the word
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_R:         next_state_s = S_EXECUTE;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_ADDI:      next_state_s = S_ADDIEX;
                    OP_J:         next_state_s = S_JUMP;
                    default: begin
                        illegal_op   = 1'b1;
                        next_state_s = exit_state_s;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    next_state_s = S_MEMREAD;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                instr_done   = 1'b1;
                next_state_s = exit_state_s;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done   = 1'b1;
                    next_state_s = exit_state_s;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_EXECUTE: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b10;
                next_state_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                reg_dst      = 1'b1;
                instr_done   = 1'b1;
                next_state_s = exit_state_s;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                next_state_s  = exit_state_s;
            end
            S_ADDIEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                next_state_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                next_state_s = exit_state_s;
            end
            S_JUMP: begin
                pc_write     = 1'b1;
                pc_source    = 2'b10;
                instr_done   = 1'b1;
                next_state_s = exit_state_s;
            end
            default: begin
                // Unused codes 13-15: everything stays low and the FSM recovers to IDLE
                next_state_s = S_IDLE;
            end
        endcase
    end

    assign state       = state_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, reset/wrap corner sequences,
// and randomized instruction streams checked against a path-level reference model.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic        clock;
    logic        reset;
    logic        run;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        instr_done, illegal_op;
    logic [15:0] instr_count;
    logic [15:0] act_ctrl;

    int checks;
    int failures;

    multicycle_control dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    assign act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Expected control word for a state, taken straight from the per-state output listing
    function automatic logic [15:0] ref_ctrl(input int st, input logic mr);
        logic pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa} = 10'b0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            1:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            2:  asb = 2'b11;
            3:  begin asa = 1'b1; asb = 2'b10; end
            4:  begin mrd = 1'b1; iod = 1'b1; end
            5:  begin rw = 1'b1; m2r = 1'b1; end
            6:  begin mwr = 1'b1; iod = 1'b1; end
            7:  begin asa = 1'b1; aop = 2'b10; end
            8:  begin rw = 1'b1; rdst = 1'b1; end
            9:  begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; psrc = 2'b01; end
            10: begin asa = 1'b1; asb = 2'b10; end
            11: rw = 1'b1;
            12: begin pcw = 1'b1; psrc = 2'b10; end
            default: ;
        endcase
        return {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    function automatic logic rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: sample away from the edge with the current inputs applied, then advance
    task automatic cyc(input string tag, input int st, input logic done, input logic ill,
                       input logic [15:0] cnt);
        @(negedge clock);
        chk({tag, " state"}, 32'(state), 32'(st));
        chk({tag, " ctrl"}, 32'(act_ctrl), 32'(ref_ctrl(st, mem_ready)));
        chk({tag, " instr_done"}, 32'(instr_done), 32'(done));
        chk({tag, " illegal_op"}, 32'(illegal_op), 32'(ill));
        chk({tag, " instr_count"}, 32'(instr_count), 32'(cnt));
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        run;
        logic [5:0]  op;
        logic        mr;
        int          st;
        logic        done;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int   st;
        logic mr;
        logic run;
        logic done;
        logic ill;
    } item_t;

    function automatic vec_t mkv(input logic r, input logic [5:0] op, input logic mr, input int st,
                                 input logic done, input logic ill, input logic [15:0] cnt);
        vec_t v;
        v.run = r; v.op = op; v.mr = mr; v.st = st; v.done = done; v.ill = ill; v.cnt = cnt;
        return v;
    endfunction

    function automatic item_t mki(input int st, input logic mr, input logic r);
        item_t it;
        it.st = st; it.mr = mr; it.run = r; it.done = 1'b0; it.ill = 1'b0;
        return it;
    endfunction

    // Randomized instruction stream: each instruction expands to its state path per its opcode class
    task automatic random_stream(input int n);
        item_t       q[$];
        logic [5:0]  op;
        logic        legal;
        logic        run_end;
        logic        in_idle;
        logic [15:0] model_cnt;
        int          k, fw, mw;
        in_idle   = 1'b1;
        model_cnt = 16'h0000;
        for (int i = 0; i < n; i++) begin
            q.delete();
            k = $urandom_range(0, 6);
            case (k)
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_ADDI;
                5: op = OP_J;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (is_legal(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            legal   = is_legal(op);
            run_end = ($urandom_range(0, 3) != 0);
            if (in_idle) q.push_back(mki(0, rb(), 1'b1));
            fw = $urandom_range(0, 2);
            repeat (fw) q.push_back(mki(1, 1'b0, rb()));
            q.push_back(mki(1, 1'b1, rb()));
            q.push_back(mki(2, rb(), rb()));
            mw = $urandom_range(0, 3);
            if (op == OP_LW) begin
                q.push_back(mki(3, rb(), rb()));
                repeat (mw) q.push_back(mki(4, 1'b0, rb()));
                q.push_back(mki(4, 1'b1, rb()));
                q.push_back(mki(5, rb(), rb()));
            end else if (op == OP_SW) begin
                q.push_back(mki(3, rb(), rb()));
                repeat (mw) q.push_back(mki(6, 1'b0, rb()));
                q.push_back(mki(6, 1'b1, rb()));
            end else if (op == OP_R) begin
                q.push_back(mki(7, rb(), rb()));
                q.push_back(mki(8, rb(), rb()));
            end else if (op == OP_BEQ) begin
                q.push_back(mki(9, rb(), rb()));
            end else if (op == OP_ADDI) begin
                q.push_back(mki(10, rb(), rb()));
                q.push_back(mki(11, rb(), rb()));
            end else if (op == OP_J) begin
                q.push_back(mki(12, rb(), rb()));
            end
            q[q.size()-1].run  = run_end;
            q[q.size()-1].done = legal;
            q[q.size()-1].ill  = !legal;
            foreach (q[j]) begin
                run       = q[j].run;
                opcode    = op;
                mem_ready = q[j].mr;
                cyc("rand", q[j].st, q[j].done, q[j].ill, model_cnt);
            end
            if (legal) model_cnt = model_cnt + 16'd1;
            in_idle = !run_end;
        end
    endtask

    vec_t vecs[$];

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        run       = 1'b1;
        opcode    = OP_R;
        mem_ready = 1'b1;

        // Outputs stay low while reset is held, even with run asserted
        repeat (2) begin
            @(negedge clock);
            chk("reset state", 32'(state), 32'd0);
            chk("reset ctrl", 32'(act_ctrl), 32'd0);
            chk("reset count", 32'(instr_count), 32'd0);
            chk("reset flags", 32'({instr_done, illegal_op}), 32'd0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;

        // run, opcode, mem_ready -> state, instr_done, illegal_op, instr_count
        vecs.push_back(mkv(1'b1, OP_R,    1'b1, 0,  1'b0, 1'b0, 16'd0));
        vecs.push_back(mkv(1'b1, OP_R,    1'b1, 1,  1'b0, 1'b0, 16'd0));
        vecs.push_back(mkv(1'b1, OP_R,    1'b1, 2,  1'b0, 1'b0, 16'd0));
        vecs.push_back(mkv(1'b1, OP_R,    1'b1, 7,  1'b0, 1'b0, 16'd0));
        vecs.push_back(mkv(1'b1, OP_R,    1'b1, 8,  1'b1, 1'b0, 16'd0));
        vecs.push_back(mkv(1'b1, OP_LW,   1'b1, 1,  1'b0, 1'b0, 16'd1));
        vecs.push_back(mkv(1'b1, OP_LW,   1'b1, 2,  1'b0, 1'b0, 16'd1));
        vecs.push_back(mkv(1'b1, OP_LW,   1'b1, 3,  1'b0, 1'b0, 16'd1));
        vecs.push_back(mkv(1'b1, OP_LW,   1'b0, 4,  1'b0, 1'b0, 16'd1));
        vecs.push_back(mkv(1'b1, OP_LW,   1'b0, 4,  1'b0, 1'b0, 16'd1));
        vecs.push_back(mkv(1'b1, OP_LW,   1'b1, 4,  1'b0, 1'b0, 16'd1));
        vecs.push_back(mkv(1'b1, OP_LW,   1'b1, 5,  1'b1, 1'b0, 16'd1));
        vecs.push_back(mkv(1'b1, OP_BEQ,  1'b1, 1,  1'b0, 1'b0, 16'd2));
        vecs.push_back(mkv(1'b1, OP_BEQ,  1'b1, 2,  1'b0, 1'b0, 16'd2));
        vecs.push_back(mkv(1'b1, OP_BEQ,  1'b1, 9,  1'b1, 1'b0, 16'd2));
        vecs.push_back(mkv(1'b1, OP_J,    1'b1, 1,  1'b0, 1'b0, 16'd3));
        vecs.push_back(mkv(1'b1, OP_J,    1'b1, 2,  1'b0, 1'b0, 16'd3));
        vecs.push_back(mkv(1'b1, OP_J,    1'b1, 12, 1'b1, 1'b0, 16'd3));
        vecs.push_back(mkv(1'b1, OP_BAD,  1'b1, 1,  1'b0, 1'b0, 16'd4));
        vecs.push_back(mkv(1'b1, OP_BAD,  1'b1, 2,  1'b0, 1'b1, 16'd4));
        vecs.push_back(mkv(1'b1, OP_R,    1'b1, 1,  1'b0, 1'b0, 16'd4));
        vecs.push_back(mkv(1'b1, OP_R,    1'b1, 2,  1'b0, 1'b0, 16'd4));
        vecs.push_back(mkv(1'b0, OP_R,    1'b1, 7,  1'b0, 1'b0, 16'd4));
        vecs.push_back(mkv(1'b0, OP_R,    1'b1, 8,  1'b1, 1'b0, 16'd4));
        vecs.push_back(mkv(1'b0, OP_R,    1'b1, 0,  1'b0, 1'b0, 16'd5));
        vecs.push_back(mkv(1'b0, OP_R,    1'b1, 0,  1'b0, 1'b0, 16'd5));
        vecs.push_back(mkv(1'b1, OP_SW,   1'b0, 0,  1'b0, 1'b0, 16'd5));
        vecs.push_back(mkv(1'b1, OP_SW,   1'b0, 1,  1'b0, 1'b0, 16'd5));
        vecs.push_back(mkv(1'b1, OP_SW,   1'b1, 1,  1'b0, 1'b0, 16'd5));
        vecs.push_back(mkv(1'b1, OP_SW,   1'b1, 2,  1'b0, 1'b0, 16'd5));
        vecs.push_back(mkv(1'b1, OP_SW,   1'b1, 3,  1'b0, 1'b0, 16'd5));
        vecs.push_back(mkv(1'b1, OP_SW,   1'b0, 6,  1'b0, 1'b0, 16'd5));
        vecs.push_back(mkv(1'b1, OP_SW,   1'b1, 6,  1'b1, 1'b0, 16'd5));
        vecs.push_back(mkv(1'b1, OP_ADDI, 1'b1, 1,  1'b0, 1'b0, 16'd6));
        vecs.push_back(mkv(1'b1, OP_ADDI, 1'b1, 2,  1'b0, 1'b0, 16'd6));
        vecs.push_back(mkv(1'b1, OP_ADDI, 1'b1, 10, 1'b0, 1'b0, 16'd6));
        vecs.push_back(mkv(1'b0, OP_ADDI, 1'b1, 11, 1'b1, 1'b0, 16'd6));
        vecs.push_back(mkv(1'b0, OP_ADDI, 1'b1, 0,  1'b0, 1'b0, 16'd7));

        foreach (vecs[i]) begin
            run       = vecs[i].run;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].mr;
            cyc($sformatf("vec%0d", i), vecs[i].st, vecs[i].done, vecs[i].ill, vecs[i].cnt);
        end

        // Reset asserted mid-MEMREAD takes effect at once and clears the count
        run       = 1'b1;
        opcode    = OP_LW;
        mem_ready = 1'b1;
        cyc("abort", 0, 1'b0, 1'b0, 16'd7);
        cyc("abort", 1, 1'b0, 1'b0, 16'd7);
        cyc("abort", 2, 1'b0, 1'b0, 16'd7);
        cyc("abort", 3, 1'b0, 1'b0, 16'd7);
        mem_ready = 1'b0;
        @(negedge clock);
        chk("abort memread state", 32'(state), 32'd4);
        chk("abort memread i_or_d", 32'(i_or_d), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort state", 32'(state), 32'd0);
        chk("abort ctrl", 32'(act_ctrl), 32'd0);
        chk("abort flags", 32'({instr_done, illegal_op}), 32'd0);
        chk("abort count", 32'(instr_count), 32'd0);
        @(posedge clock);
        #1;
        chk("abort held state", 32'(state), 32'd0);
        reset     = 1'b1;
        mem_ready = 1'b1;

        // Counter wrap from 0xFFFF on an addi retire
        opcode = OP_ADDI;
        force dut.count_r = 16'hFFFF;
        #1;
        release dut.count_r;
        cyc("wrap", 0,  1'b0, 1'b0, 16'hFFFF);
        cyc("wrap", 1,  1'b0, 1'b0, 16'hFFFF);
        cyc("wrap", 2,  1'b0, 1'b0, 16'hFFFF);
        cyc("wrap", 10, 1'b0, 1'b0, 16'hFFFF);
        cyc("wrap", 11, 1'b1, 1'b0, 16'hFFFF);
        cyc("wrap", 1,  1'b0, 1'b0, 16'h0000);

        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        random_stream(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
